// File: rtl/ex_wb_if.sv
// Decoded-instruction bundle, fetch control and data-memory handshake of the ex_wb stage.
// The slave modport is the execute stage; master is its environment (decode + memory).
interface ex_wb_if;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_imm;
  logic        dec_imm_sel;
  logic        dec_alu;
  logic        dec_lui;
  logic        dec_jal;
  logic        dec_jalr;
  logic        dec_branch;
  logic        dec_mem_write;
  logic        dec_mem_to_reg;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic [2:0]  dec_func3;
  logic        dec_subtype;
  logic        stall;
  logic [31:0] fetch_pc;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        exception;

  modport slave (
    input  dec_valid, dec_pc, dec_imm, dec_imm_sel, dec_alu, dec_lui, dec_jal, dec_jalr,
           dec_branch, dec_mem_write, dec_mem_to_reg, dec_rs1, dec_rs2, dec_rd,
           dec_func3, dec_subtype, dmem_ack, dmem_rdata,
    output stall, fetch_pc, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, exception
  );

  modport master (
    output dec_valid, dec_pc, dec_imm, dec_imm_sel, dec_alu, dec_lui, dec_jal, dec_jalr,
           dec_branch, dec_mem_write, dec_mem_to_reg, dec_rs1, dec_rs2, dec_rd,
           dec_func3, dec_subtype, dmem_ack, dmem_rdata,
    input  stall, fetch_pc, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, exception
  );
endinterface

// File: rtl/ex_wb.sv
// RV32I execute/write-back stage: register file, ALU, branch/jump resolution,
// load/store handshake and next-fetch-PC generation with stall back-pressure.
module ex_wb #(
  parameter logic [31:0] RESET = 32'h0000_0000
) (
  input  logic   clk,
  input  logic   reset,
  ex_wb_if.slave bus
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_MEM    = 2'd1;
  localparam logic [1:0] S_BUBBLE = 2'd2;

  logic [31:0] r_regs [32];
  logic [1:0]  r_state;
  logic [31:0] r_fetch_pc;
  logic        r_exception;
  logic        r_dmem_req;
  logic        r_dmem_we;
  logic [31:0] r_dmem_addr;
  logic [31:0] r_dmem_wdata;
  logic [3:0]  r_dmem_wstrb;
  logic        r_ld_is_load;
  logic [4:0]  r_ld_rd;
  logic [2:0]  r_ld_func3;
  logic [1:0]  r_ld_ea;

  logic [31:0] w_op1, w_rs2v, w_op2, w_alu, w_result, w_ea, w_target;
  logic [31:0] w_lane, w_ld_data, w_st_data, w_wdata;
  logic [3:0]  w_st_strb;
  logic [4:0]  w_waddr;
  logic        w_taken, w_mem_op, w_misaligned, w_redirect, w_we, w_run;

  // Operand fetch, ALU, branch resolution and load/store formatting.
  always_comb begin
    w_op1    = (bus.dec_rs1 == 5'd0) ? 32'd0 : r_regs[bus.dec_rs1];
    w_rs2v   = (bus.dec_rs2 == 5'd0) ? 32'd0 : r_regs[bus.dec_rs2];
    w_op2    = bus.dec_imm_sel ? bus.dec_imm : w_rs2v;
    w_alu    = 32'd0;
    w_taken  = 1'b0;
    case (bus.dec_func3)
      3'b000:  w_alu = bus.dec_subtype ? (w_op1 - w_op2) : (w_op1 + w_op2);
      3'b001:  w_alu = w_op1 << w_op2[4:0];
      3'b010:  w_alu = {31'd0, $signed(w_op1) < $signed(w_op2)};
      3'b011:  w_alu = {31'd0, w_op1 < w_op2};
      3'b100:  w_alu = w_op1 ^ w_op2;
      3'b101:  w_alu = bus.dec_subtype ? 32'($signed(w_op1) >>> w_op2[4:0]) : (w_op1 >> w_op2[4:0]);
      3'b110:  w_alu = w_op1 | w_op2;
      3'b111:  w_alu = w_op1 & w_op2;
      default: w_alu = 32'd0;
    endcase
    case (bus.dec_func3)
      3'b000:  w_taken = (w_op1 == w_rs2v);
      3'b001:  w_taken = (w_op1 != w_rs2v);
      3'b100:  w_taken = ($signed(w_op1) < $signed(w_rs2v));
      3'b101:  w_taken = ($signed(w_op1) >= $signed(w_rs2v));
      3'b110:  w_taken = (w_op1 < w_rs2v);
      3'b111:  w_taken = (w_op1 >= w_rs2v);
      default: w_taken = 1'b0;
    endcase
    w_ea         = w_op1 + bus.dec_imm;
    w_mem_op     = bus.dec_mem_write | bus.dec_mem_to_reg;
    w_misaligned = w_mem_op & (((bus.dec_func3[1:0] == 2'b01) & w_ea[0]) |
                               ((bus.dec_func3[1:0] == 2'b10) & (w_ea[1:0] != 2'b00)));
    w_redirect   = ~w_mem_op & (bus.dec_jal | bus.dec_jalr | (bus.dec_branch & w_taken));
    w_target     = bus.dec_jalr ? (w_ea & 32'hFFFF_FFFE) : (bus.dec_pc + bus.dec_imm);
    if (bus.dec_lui) begin
      w_result = bus.dec_imm;
    end else if (bus.dec_jal | bus.dec_jalr) begin
      w_result = bus.dec_pc + 32'd4;
    end else begin
      w_result = w_alu;
    end
    case (bus.dec_func3[1:0])
      2'b00:   begin w_st_data = {4{w_rs2v[7:0]}};  w_st_strb = 4'b0001 << w_ea[1:0]; end
      2'b01:   begin w_st_data = {2{w_rs2v[15:0]}}; w_st_strb = 4'b0011 << w_ea[1:0]; end
      default: begin w_st_data = w_rs2v;           w_st_strb = 4'b1111;              end
    endcase
    w_lane = bus.dmem_rdata >> {r_ld_ea, 3'b000};
    case (r_ld_func3)
      3'b000:  w_ld_data = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_ld_data = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_ld_data = {24'd0, w_lane[7:0]};
      3'b101:  w_ld_data = {16'd0, w_lane[15:0]};
      default: w_ld_data = w_lane;
    endcase
    w_run = (r_state == S_RUN);
    if (r_state == S_MEM) begin
      w_we    = bus.dmem_ack & r_dmem_req & r_ld_is_load;
      w_waddr = r_ld_rd;
      w_wdata = w_ld_data;
    end else begin
      // Branches carry no destination; misaligned accesses retire as no-ops.
      w_we    = w_run & bus.dec_valid & ~w_mem_op & ~bus.dec_branch;
      w_waddr = bus.dec_rd;
      w_wdata = w_result;
    end
  end

  assign bus.stall      = ~w_run | (bus.dec_valid & ((w_mem_op & ~w_misaligned) | w_redirect));
  assign bus.fetch_pc   = r_fetch_pc;
  assign bus.exception  = r_exception;
  assign bus.dmem_req   = r_dmem_req;
  assign bus.dmem_we    = r_dmem_we;
  assign bus.dmem_addr  = r_dmem_addr;
  assign bus.dmem_wdata = r_dmem_wdata;
  assign bus.dmem_wstrb = r_dmem_wstrb;

  // Register file write port; x0 is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else if (w_we && (w_waddr != 5'd0)) begin
      r_regs[w_waddr] <= w_wdata;
    end
  end

  // Sequencing FSM, fetch PC, memory request and sticky exception.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_RUN;
      r_fetch_pc   <= RESET;
      r_exception  <= 1'b0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= 32'd0;
      r_dmem_wdata <= 32'd0;
      r_dmem_wstrb <= 4'd0;
      r_ld_is_load <= 1'b0;
      r_ld_rd      <= 5'd0;
      r_ld_func3   <= 3'd0;
      r_ld_ea      <= 2'd0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (!bus.dec_valid) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
          end else if (w_misaligned) begin
            r_exception <= 1'b1;
            r_fetch_pc  <= r_fetch_pc + 32'd4;
          end else if (w_mem_op) begin
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= bus.dec_mem_write;
            r_dmem_addr  <= {w_ea[31:2], 2'b00};
            r_dmem_wdata <= bus.dec_mem_write ? w_st_data : 32'd0;
            r_dmem_wstrb <= bus.dec_mem_write ? w_st_strb : 4'd0;
            r_ld_is_load <= bus.dec_mem_to_reg & ~bus.dec_mem_write;
            r_ld_rd      <= bus.dec_rd;
            r_ld_func3   <= bus.dec_func3;
            r_ld_ea      <= w_ea[1:0];
            r_state      <= S_MEM;
          end else if (w_redirect) begin
            r_fetch_pc <= w_target;
            r_state    <= S_BUBBLE;
          end else begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
          end
        end
        S_MEM: begin
          if (bus.dmem_ack && r_dmem_req) begin
            r_dmem_req <= 1'b0;
            r_fetch_pc <= r_fetch_pc + 32'd4;
            r_state    <= S_RUN;
          end
        end
        S_BUBBLE: r_state <= S_RUN;
        default:  r_state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_wb.sv
// Randomized self-checking bench for ex_wb against an instruction-level reference model.
module tb_ex_wb;
  localparam int K_ALU = 0, K_LUI = 1, K_JAL = 2, K_JALR = 3, K_BR = 4, K_LD = 5, K_ST = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_wb_if bus ();
  ex_wb #(.RESET(32'h0000_0000)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0] m_x [32];
  logic [31:0] m_pc;
  logic        m_exc;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic sub,
                                          input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return sub ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return sub ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic br_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ld_ref(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] rd);
    logic [31:0] lane;
    lane = rd >> (8 * int'(lo));
    case (f3)
      3'd0: return {{24{lane[7]}}, lane[7:0]};
      3'd1: return {{16{lane[15]}}, lane[15:0]};
      3'd4: return {24'd0, lane[7:0]};
      3'd5: return {16'd0, lane[15:0]};
      default: return lane;
    endcase
  endfunction

  task automatic idle(input logic ack);
    bus.dmem_ack = ack;
    @(posedge clk);
    m_pc = m_pc + 32'd4;
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    #1 chk_val("idle_pc", bus.fetch_pc, m_pc);
    chk_val("idle_stall", {31'd0, bus.stall}, 32'd0);
  endtask

  // Called just after a negedge with dec_valid low; returns in the same situation.
  task automatic issue(input int kind, input logic [2:0] f3, input logic sub, input logic isel,
                       input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] pc, input int dly,
                       input logic [31:0] rdata);
    logic [31:0] a, b, op2, ea, target, res, exp_wd;
    logic [3:0]  exp_st;
    logic        mem, mis, redir;
    a   = m_x[rs1];
    b   = m_x[rs2];
    op2 = isel ? imm : b;
    ea  = a + imm;
    mem = (kind == K_LD) || (kind == K_ST);
    mis = mem && (((f3[1:0] == 2'd1) && ea[0]) || ((f3[1:0] == 2'd2) && (ea[1:0] != 2'd0)));
    redir  = (kind == K_JAL) || (kind == K_JALR) || ((kind == K_BR) && br_ref(f3, a, b));
    target = (kind == K_JALR) ? (ea & 32'hFFFF_FFFE) : pc + imm;
    res    = (kind == K_LUI) ? imm : ((kind == K_JAL) || (kind == K_JALR)) ? pc + 32'd4
                                   : alu_ref(f3, sub, a, op2);
    case (f3[1:0])
      2'd0:    begin exp_wd = {4{b[7:0]}};  exp_st = 4'b0001 << ea[1:0]; end
      2'd1:    begin exp_wd = {2{b[15:0]}}; exp_st = 4'b0011 << ea[1:0]; end
      default: begin exp_wd = b;            exp_st = 4'b1111;           end
    endcase
    bus.dec_valid = 1'b1;          bus.dec_pc = pc;        bus.dec_imm = imm;
    bus.dec_imm_sel = isel;        bus.dec_alu = (kind == K_ALU);
    bus.dec_lui = (kind == K_LUI); bus.dec_jal = (kind == K_JAL);
    bus.dec_jalr = (kind == K_JALR); bus.dec_branch = (kind == K_BR);
    bus.dec_mem_write = (kind == K_ST); bus.dec_mem_to_reg = (kind == K_LD);
    bus.dec_rs1 = rs1; bus.dec_rs2 = rs2; bus.dec_rd = rd;
    bus.dec_func3 = f3; bus.dec_subtype = sub;
    #1 chk_val("stall_exec", {31'd0, bus.stall}, {31'd0, (mem && !mis) || redir});
    @(posedge clk);
    if (mem && !mis) begin
      @(negedge clk);
      bus.dec_valid = 1'($urandom_range(0, 1));
      #1 chk_val("mem_req", {31'd0, bus.dmem_req}, 32'd1);
      chk_val("mem_we", {31'd0, bus.dmem_we}, {31'd0, kind == K_ST});
      chk_val("mem_addr", bus.dmem_addr, {ea[31:2], 2'b00});
      chk_val("mem_pc_hold", bus.fetch_pc, m_pc);
      if (kind == K_ST) begin
        chk_val("st_wdata", bus.dmem_wdata, exp_wd);
        chk_val("st_wstrb", {28'd0, bus.dmem_wstrb}, {28'd0, exp_st});
      end
      for (int i = 0; i < dly; i++) begin
        chk_val("mem_stall", {31'd0, bus.stall}, 32'd1);
        @(negedge clk);
        #1 chk_val("mem_req_wait", {31'd0, bus.dmem_req}, 32'd1);
      end
      chk_val("mem_stall_ack", {31'd0, bus.stall}, 32'd1);
      bus.dmem_ack = 1'b1;
      bus.dmem_rdata = rdata;
      @(posedge clk);
      if (kind == K_LD && rd != 5'd0) m_x[rd] = ld_ref(f3, ea[1:0], rdata);
      m_pc = m_pc + 32'd4;
      @(negedge clk);
      bus.dmem_ack = 1'b0;
      bus.dec_valid = 1'b0;
      #1 chk_val("mem_done_req", {31'd0, bus.dmem_req}, 32'd0);
      chk_val("mem_done_stall", {31'd0, bus.stall}, 32'd0);
      chk_val("mem_done_pc", bus.fetch_pc, m_pc);
    end else if (redir) begin
      if (kind != K_BR && rd != 5'd0) m_x[rd] = res;
      m_pc = target;
      @(negedge clk);
      bus.dec_rd = 5'd31;
      #1 chk_val("bubble_stall", {31'd0, bus.stall}, 32'd1);
      chk_val("redirect_pc", bus.fetch_pc, m_pc);
      @(posedge clk);
      @(negedge clk);
      bus.dec_valid = 1'b0;
      #1 chk_val("after_bubble_stall", {31'd0, bus.stall}, 32'd0);
      chk_val("after_bubble_pc", bus.fetch_pc, m_pc);
    end else begin
      if (!mem && kind != K_BR && rd != 5'd0) m_x[rd] = res;
      if (mis) m_exc = 1'b1;
      m_pc = m_pc + 32'd4;
      @(negedge clk);
      bus.dec_valid = 1'b0;
      #1 chk_val("seq_pc", bus.fetch_pc, m_pc);
      chk_val("seq_req", {31'd0, bus.dmem_req}, 32'd0);
    end
    chk_val("exception", {31'd0, bus.exception}, {31'd0, m_exc});
  endtask

  task automatic chk_reg(input logic [4:0] r);
    issue(K_ST, 3'd2, 1'b0, 1'b1, 32'd0, 5'd0, r, 5'd0, 32'h0, 0, 32'd0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
    m_pc  = 32'h0000_0000;
    m_exc = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [2:0] ld_f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    int kind;
    logic [2:0] f3;
    logic isel, sub;
    bus.dec_valid = 1'b0; bus.dec_pc = 32'd0; bus.dec_imm = 32'd0; bus.dec_imm_sel = 1'b0;
    bus.dec_alu = 1'b0; bus.dec_lui = 1'b0; bus.dec_jal = 1'b0; bus.dec_jalr = 1'b0;
    bus.dec_branch = 1'b0; bus.dec_mem_write = 1'b0; bus.dec_mem_to_reg = 1'b0;
    bus.dec_rs1 = 5'd0; bus.dec_rs2 = 5'd0; bus.dec_rd = 5'd0; bus.dec_func3 = 3'd0;
    bus.dec_subtype = 1'b0; bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'd0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 chk_val("rst_pc", bus.fetch_pc, 32'h0000_0000);
    chk_val("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk_val("rst_exc", {31'd0, bus.exception}, 32'd0);
    chk_val("rst_req", {31'd0, bus.dmem_req}, 32'd0);
    chk_val("rst_we", {31'd0, bus.dmem_we}, 32'd0);
    chk_val("rst_addr", bus.dmem_addr, 32'd0);
    chk_val("rst_wdata", bus.dmem_wdata, 32'd0);
    chk_val("rst_wstrb", {28'd0, bus.dmem_wstrb}, 32'd0);
    reset = 1'b1;
    idle(1'b1);

    // Directed sequence from the bring-up plan.
    issue(K_ALU, 3'd0, 1'b0, 1'b1, 32'd5, 5'd0, 5'd0, 5'd1, 32'h0, 0, 32'd0);
    issue(K_ALU, 3'd0, 1'b0, 1'b1, 32'hFFFF_FFFD, 5'd0, 5'd0, 5'd2, 32'h4, 0, 32'd0);
    issue(K_ALU, 3'd0, 1'b1, 1'b0, 32'd0, 5'd1, 5'd2, 5'd3, 32'h8, 0, 32'd0);
    issue(K_ALU, 3'd2, 1'b0, 1'b0, 32'd0, 5'd2, 5'd1, 5'd4, 32'hC, 0, 32'd0);
    issue(K_ALU, 3'd3, 1'b0, 1'b0, 32'd0, 5'd2, 5'd1, 5'd5, 32'h10, 0, 32'd0);
    issue(K_LUI, 3'd0, 1'b0, 1'b1, 32'h8000_0000, 5'd0, 5'd0, 5'd8, 32'h14, 0, 32'd0);
    issue(K_ALU, 3'd5, 1'b1, 1'b1, 32'd4, 5'd8, 5'd0, 5'd9, 32'h18, 0, 32'd0);
    chk_val("x3_sub", m_x[3], 32'd8);
    chk_val("x9_sra", m_x[9], 32'hF800_0000);
    issue(K_ST, 3'd2, 1'b0, 1'b1, 32'h100, 5'd0, 5'd3, 5'd0, 32'h1C, 2, 32'd0);
    issue(K_LD, 3'd0, 1'b0, 1'b1, 32'h103, 5'd0, 5'd0, 5'd6, 32'h20, 1, 32'h8012_3456);
    issue(K_LD, 3'd4, 1'b0, 1'b1, 32'h103, 5'd0, 5'd0, 5'd10, 32'h24, 0, 32'h8012_3456);
    issue(K_BR, 3'd0, 1'b0, 1'b0, 32'd16, 5'd1, 5'd1, 5'd0, 32'h20, 0, 32'd0);
    issue(K_BR, 3'd1, 1'b0, 1'b0, 32'd16, 5'd1, 5'd1, 5'd0, 32'h30, 0, 32'd0);
    issue(K_ALU, 3'd0, 1'b0, 1'b1, 32'h41, 5'd0, 5'd0, 5'd1, 32'h34, 0, 32'd0);
    issue(K_JALR, 3'd0, 1'b0, 1'b1, 32'd2, 5'd1, 5'd0, 5'd7, 32'h38, 0, 32'd0);
    issue(K_LD, 3'd2, 1'b0, 1'b1, 32'h102, 5'd0, 5'd0, 5'd11, 32'h42, 0, 32'h1234_5678);
    issue(K_ALU, 3'd6, 1'b0, 1'b1, 32'h0F0, 5'd3, 5'd0, 5'd12, 32'h46, 0, 32'd0);
    idle(1'b1);
    for (int r = 1; r < 13; r++) chk_reg(5'(r));

    // Randomized instruction mix.
    for (int n = 0; n < 250; n++) begin
      kind = int'($urandom_range(0, 6));
      isel = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      sub  = 1'b0;
      if (kind == K_ALU && (f3 == 3'd5 || (f3 == 3'd0 && !isel))) sub = 1'($urandom_range(0, 1));
      if (kind == K_LD) f3 = ld_f3s[$urandom_range(0, 4)];
      if (kind == K_ST) f3 = 3'($urandom_range(0, 2));
      if (kind == K_LD || kind == K_ST) isel = 1'b1;
      issue(kind, f3, sub, isel,
            (kind == K_LD || kind == K_ST) ? 32'($urandom_range(0, 63)) : $urandom(),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            (kind == K_BR) ? 5'd0 : 5'($urandom_range(0, 31)),
            $urandom() & 32'hFFFF_FFFC, int'($urandom_range(0, 3)), $urandom());
      if ($urandom_range(0, 7) == 0) idle(1'($urandom_range(0, 1)));
    end
    for (int r = 0; r < 32; r++) chk_reg(5'(r));

    // Reset while a load waits for its ack.
    bus.dec_valid = 1'b1; bus.dec_alu = 1'b0; bus.dec_lui = 1'b0; bus.dec_jal = 1'b0;
    bus.dec_jalr = 1'b0; bus.dec_branch = 1'b0; bus.dec_mem_write = 1'b0;
    bus.dec_mem_to_reg = 1'b1; bus.dec_rs1 = 5'd0; bus.dec_imm = 32'h200;
    bus.dec_imm_sel = 1'b1; bus.dec_rd = 5'd9; bus.dec_func3 = 3'd2;
    @(negedge clk);
    bus.dec_valid = 1'b0;
    #1 chk_val("pre_abort_req", {31'd0, bus.dmem_req}, 32'd1);
    reset = 1'b0;
    #1 chk_val("abort_req", {31'd0, bus.dmem_req}, 32'd0);
    chk_val("abort_pc", bus.fetch_pc, 32'h0000_0000);
    chk_val("abort_exc", {31'd0, bus.exception}, 32'd0);
    model_reset();
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    reset = 1'b1;
    idle(1'b1);
    chk_reg(5'd9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ex_wb.md
# ex_wb

Execute/write-back stage of the three-stage RV32I pipeline, directly downstream of fetch/decode. It consumes the registered decoded-instruction bundle and holds the 32×32 register file, ALU, branch/jump resolution and the data-memory load/store handshake. It produces the next fetch PC and the stall back-pressure for fetch/decode.

## Interface
Parameters:
- RESET, 32'h0000_0000, fetch PC loaded on reset

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- dec_valid  in  1  decoded bundle valid this cycle
- dec_pc  in  32  PC of decoded instruction
- dec_imm  in  32  decoded immediate
- dec_imm_sel  in  1  op2 = immediate (else rs2)
- dec_alu, dec_lui, dec_jal, dec_jalr, dec_branch, dec_mem_write, dec_mem_to_reg  in  1 each  instruction class
- dec_rs1, dec_rs2, dec_rd  in  5 each  register selects
- dec_func3  in  3  funct3
- dec_subtype  in  1  SUB/SRA select (already cleared for ADDI)
- stall  out  1  hold fetch/decode
- fetch_pc  out  32  address of next instruction fetch
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  store data, lanes replicated
- dmem_wstrb  out  4  byte enables
- dmem_ack  in  1  access done; load data valid
- dmem_rdata  in  32  load data word
- exception  out  1  sticky misaligned data access

## Operation
- Register file: x0 reads 0, writes to x0 dropped. Two combinational read ports; one write at posedge.
- op1 = x[rs1]. op2 = dec_imm_sel ? dec_imm : x[rs2].
- ALU by func3:
  - 000: ADD/SUB (dec_subtype)
  - 001: SLL by op2[4:0]
  - 010: SLT (signed)
  - 011: SLTU
  - 100: XOR
  - 101: SRL/SRA (dec_subtype)
  - 110: OR
  - 111: AND
- All arithmetic mod 2^32.
- LUI result = dec_imm. JAL/JALR result = dec_pc+4.
- Branch condition by func3:
  - BEQ 000, BNE 001
  - BLT 100, BGE 101 (signed)
  - BLTU 110, BGEU 111
  - 010/011: not taken
- Redirect target:
  - JAL / taken branch: dec_pc+dec_imm
  - JALR: (x[rs1]+dec_imm) & ~1
- Loads, func3 LB/LH/LW/LBU/LHU: lane selected by ea[1:0], sign- or zero-extended.
- Stores, func3 SB/SH/SW: wstrb = 0001<<ea[1:0] / 0011<<ea[1:0] / 1111. wdata = {4{b}} / {2{h}} / w.
- Misaligned access (LH/LHU/SH with ea[0]=1; LW/SW with ea[1:0]≠0):
  - exception set (sticky until reset)
  - no request issued, no register write
  - treated as an ALU no-op
- FSM states RUN, MEM, BUBBLE.
- RUN, dec_valid=0: fetch_pc += 4. No write.
- RUN, dec_valid=1, ALU/LUI/JAL/JALR/non-taken branch: write rd at edge.
  - No redirect: fetch_pc += 4, stay RUN.
  - Redirect: fetch_pc <= target, → BUBBLE.
- RUN, dec_valid=1, aligned load/store: at edge, register dmem_req=1, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb and latch rd/func3/ea[1:0]; → MEM. fetch_pc holds.
- MEM: request fields stable and stall=1 until dmem_ack.
  - On ack edge: load writes extracted data to rd.
  - dmem_req <= 0, fetch_pc += 4, → RUN.
- BUBBLE: stall=1, dec_valid ignored, fetch_pc holds. → RUN next cycle.
- stall = (state≠RUN) | (state==RUN & dec_valid & (aligned mem op | redirect)).

## Timing
- Reset values:
  - fetch_pc=RESET, stall=0, exception=0
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_wstrb=0
  - all registers 0, state RUN
- Reset mid-MEM aborts: dmem_req drops asynchronously and the pending load is discarded.
- ALU/jump result visible to the next instruction's read in the following cycle. No forwarding needed.
- Load/store occupancy = 2 + (cycles until ack).
  - dmem_req rises the cycle after dec_valid.
  - ack is accepted in that same cycle at the earliest.
- Redirect costs 2 cycles: execute cycle, then BUBBLE. stall is high in both.
- dmem_ack while dmem_req=0 is ignored.
- Writes to rd=0 on load are dropped, but the access still completes.

## Test plan
- ADDI x1,x0,5; ADDI x2,x0,-3; SUB x3,x1,x2 -> x3=8. SLT x4,x2,x1=1. SLTU x5,x2,x1=0. SRA of 0x8000_0000 by 4 = 0xF800_0000.
- SW x3 (8) to 0x100, ack after 3 cycles -> dmem_we=1, wstrb=1111, addr=0x100, stall high 4 cycles. Then LB x6 from 0x103 with rdata=0x80xx_xxxx -> x6=0xFFFF_FF80. LBU -> 0x80.
- BEQ x1,x1,+16 at pc 0x20 -> fetch_pc=0x30, stall high 2 cycles. BNE x1,x1 -> not taken, fetch_pc keeps +4.
- JALR x7,x1,2 with x1=0x41 -> fetch_pc=0x42 (bit0 cleared), x7=pc+4.
- LW at 0x102 -> exception=1, dmem_req stays 0, rd unchanged. Subsequent ALU ops still execute.
- Assert reset while in MEM awaiting ack -> dmem_req=0 immediately, fetch_pc=RESET, load never written.
